// File: rtl/delayed_commit_unit.sv
// delayed_commit_unit: computes a bitwise reduction of b and c (OR/AND/XOR/pass b)
// and commits it to d a programmable number of cycles after start. In intra mode
// (sem=0) the operands are sampled at start; in inter mode (sem=1) they are
// sampled on the commit edge itself.
module delayed_commit_unit #(
  parameter int unsigned            WIDTH   = 8,
  parameter int unsigned            CNT_W   = 6,
  parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cancel,
  input  logic             sem,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] delay,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] hold_q,  hold_d;
  logic [WIDTH-1:0] d_q,     d_d;
  logic [1:0]       op_q,    op_d;
  logic             sem_q,   sem_d;
  logic             done_q,  done_d;
  logic             err_q,   err_d;

  // Bitwise reduction selected by op; no carries, result is exactly WIDTH bits.
  function automatic logic [WIDTH-1:0] reduce(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    case (sel)
      2'b00:   reduce = x | y;
      2'b01:   reduce = x & y;
      2'b10:   reduce = x ^ y;
      default: reduce = x;
    endcase
  endfunction

  // State register: every flop in the block, cleared asynchronously.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      // NOTE: the hold register is a plain flop, not a memory, so it is reset
      // along with everything else; a stale intra capture can never leak out.
      hold_q  <= '0;
      d_q     <= RST_VAL;
      op_q    <= 2'b00;
      sem_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      d_q     <= d_d;
      op_q    <= op_d;
      sem_q   <= sem_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: start acceptance, countdown, commit and cancel.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    d_d     = d_q;
    op_d    = op_q;
    sem_d   = sem_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Cancel has nothing to abort here; start is taken regardless.
        if (start) begin
          sem_d   = sem;
          op_d    = op;
          // delay=0 behaves as delay=1: commit on the very next edge.
          cnt_d   = (delay == '0) ? '0 : delay - CNT_W'(1);
          if (!sem) hold_d = reduce(op, b, c);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cancel) begin
          // Cancel beats both a concurrent start and a due commit.
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          if (start) err_d = 1'b1;
          if (cnt_q == '0) begin
            d_d     = sem_q ? reduce(op_q, b, c) : hold_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: busy follows the state, the rest are registered.
  always_comb begin
    busy = (state_q == S_WAIT);
    d    = d_q;
    done = done_q;
    err  = err_q;
  end

endmodule

// File: tb/tb_delayed_commit_unit.sv
// Scoreboard bench for delayed_commit_unit: each accepted start pushes the
// hand-computed result and commit cycle; a monitor pops on every done pulse.
module tb_delayed_commit_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cancel, sem;
  logic [1:0] op;
  logic [5:0] delay;
  logic [7:0] b, c, d;
  logic       busy, done, err;

  typedef struct {
    logic [7:0] val;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   passed = 0;
  int   total  = 0;

  delayed_commit_unit #(.WIDTH(8), .CNT_W(6), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel), .sem(sem),
    .op(op), .delay(delay), .b(b), .c(c), .d(d), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name,
                       input int act, input int exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          check(1'b0, "unexpected_done", int'(d), 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check(d === e.val, "commit_value", int'(d), int'(e.val));
          check(cyc == e.cyc, "commit_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; optionally record the expected commit.
  task automatic issue(input logic s, input logic [1:0] o, input logic [5:0] dl,
                       input logic [7:0] bb, input logic [7:0] cc,
                       input logic [7:0] exp_d, input bit push);
    sem = s; op = o; delay = dl; b = bb; c = cc; start = 1'b1;
    tick();
    start = 1'b0;
    if (push) q.push_back('{exp_d, cyc + ((dl == 0) ? 1 : int'(dl))});
  endtask

  task automatic wait_done(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) check(1'b0, "done_timeout", 0, 1);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && q.size() != 0; i++) tick();
    check(q.size() == 0, "pending_commits", q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; sem = 1'b0;
    op = 2'b00; delay = '0; b = '0; c = '0;
    #12;
    check(d === 8'h00 && busy === 1'b0 && done === 1'b0 && err === 1'b0,
          "reset_state", int'({busy, done, err, d}), 0);
    rst_n = 1'b1;
    tick();

    // Intra: b sampled at start, later change to b has no effect.
    issue(1'b0, 2'b00, 6'd25, 8'h01, 8'h00, 8'h01, 1'b1);
    check(busy === 1'b1, "intra_busy", int'(busy), 1);
    repeat (9) tick();
    b = 8'h00;
    drain(40);

    // Inter: same stimulus, b sampled on the commit edge.
    issue(1'b1, 2'b00, 6'd25, 8'h01, 8'h00, 8'h00, 1'b1);
    repeat (9) tick();
    b = 8'h00;
    drain(40);
    check(busy === 1'b0, "idle_after_commit", int'(busy), 0);

    // All four ops back-to-back, each started in the previous done cycle.
    issue(1'b0, 2'b00, 6'd3, 8'hF0, 8'h3C, 8'hFC, 1'b1);
    wait_done(10);
    issue(1'b0, 2'b01, 6'd3, 8'hF0, 8'h3C, 8'h30, 1'b1);
    wait_done(10);
    issue(1'b0, 2'b10, 6'd3, 8'hF0, 8'h3C, 8'hCC, 1'b1);
    wait_done(10);
    issue(1'b0, 2'b11, 6'd3, 8'hF0, 8'h3C, 8'hF0, 1'b1);
    drain(10);

    // delay=0 behaves as delay=1.
    issue(1'b0, 2'b10, 6'd0, 8'hAA, 8'h55, 8'hFF, 1'b1);
    drain(10);

    // Maximum delay.
    issue(1'b1, 2'b01, 6'd63, 8'hFF, 8'h0F, 8'h0F, 1'b1);
    drain(80);

    // Start during WAIT: err pulse, original commit untouched.
    issue(1'b0, 2'b00, 6'd5, 8'h12, 8'h21, 8'h33, 1'b1);
    tick();
    issue(1'b0, 2'b11, 6'd1, 8'h00, 8'h00, 8'h00, 1'b0);
    check(err === 1'b1, "err_pulse", int'(err), 1);
    tick();
    check(err === 1'b0, "err_one_cycle", int'(err), 0);
    drain(10);

    // Cancel mid-WAIT: no commit, d holds 0x33.
    issue(1'b0, 2'b00, 6'd10, 8'hFF, 8'hFF, 8'h00, 1'b0);
    repeat (3) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check(busy === 1'b0, "cancel_busy", int'(busy), 0);
    check(d === 8'h33, "cancel_d_hold", int'(d), 8'h33);

    // Cancel together with start in WAIT: cancel wins, no err.
    issue(1'b0, 2'b00, 6'd10, 8'hFF, 8'hFF, 8'h00, 1'b0);
    repeat (8) tick();
    cancel = 1'b1;
    issue(1'b0, 2'b00, 6'd2, 8'h0F, 8'h00, 8'h00, 1'b0);
    cancel = 1'b0;
    check(busy === 1'b0 && err === 1'b0, "cancel_start",
          int'({busy, err}), 0);
    repeat (15) tick();
    check(d === 8'h33, "cancel_no_commit", int'(d), 8'h33);

    // Asynchronous reset mid-WAIT.
    issue(1'b0, 2'b00, 6'd20, 8'h5A, 8'h00, 8'h00, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check(d === 8'h00 && busy === 1'b0, "async_reset",
          int'({busy, d}), 0);
    tick();
    rst_n = 1'b1;
    repeat (25) tick();
    check(busy === 1'b0 && d === 8'h00, "no_commit_after_reset",
          int'({busy, d}), 0);
    drain(5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/delayed_commit_unit.md
Name: delayed_commit_unit

Overview:
- Synthesisable, clocked successor to the delay-assignment teaching blocks: computes a selectable bitwise reduction of two operand vectors and commits it to output d after a programmable number of clock cycles.
- Supports both delay semantics. Intra-assignment mode samples the operands at start and commits later. Inter-assignment mode waits first, then samples and commits.
- Used in the assignment bench library as a timing-semantics demonstrator and as a generic delayed-update register.

Parameters:
WIDTH, 8, bit width of operands b, c and result d
CNT_W, 6, width of delay input and internal down-counter (max delay 2^CNT_W-1 cycles)
RST_VAL, 0, reset/initial value of d (WIDTH bits, zero-extended)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request a delayed commit; accepted only when idle
cancel  input  1  abort pending commit
sem  input  1  0 = intra-assignment (sample at start), 1 = inter-assignment (sample at commit)
op  input  2  00 OR, 01 AND, 10 XOR, 11 pass b
delay  input  CNT_W  commit delay in clock cycles, sampled at start
b  input  WIDTH  operand b
c  input  WIDTH  operand c
d  output  WIDTH  committed result (registered)
busy  output  1  high while a commit is pending
done  output  1  one-cycle pulse on the cycle d is updated
err  output  1  one-cycle pulse when start arrives while busy

Behaviour:
- Reset (rst_n low, asynchronous): d=RST_VAL, busy=0, done=0, err=0, state IDLE, counter=0, hold register=0, latched sem/op=0.
- States:
  - IDLE: busy=0. Start at edge k latches sem, op and Deff=max(delay,1). It loads counter=Deff-1 and goes to WAIT.
  - Intra capture: when sem=0, the start edge also captures hold=f(op,b,c) from the values at edge k.
  - WAIT: busy=1. Each edge with counter>0 decrements the counter.
  - Commit: at the edge where counter==0, d is written with:
    - hold when latched sem=0;
    - f(op,b,c) from the current inputs at that edge when latched sem=1.
  - After commit: done=1 for the following cycle and the state returns to IDLE.
- Latency: d changes on edge k+Deff, and done is high during cycle k+Deff. delay=0 behaves exactly as delay=1.
- Back-to-back: start may be reasserted in the cycle done is high (state is IDLE), giving zero idle gap.
- Start while in WAIT: ignored, pending commit unaffected, err pulses for one cycle.
- Cancel in WAIT: returns to IDLE on that edge with no commit and no done; d holds its value.
- Cancel in IDLE: no effect. If start is also high in IDLE, start is accepted.
- Cancel and start together in WAIT: cancel wins, start ignored, err=0.
- Cancel on the commit edge (WAIT, counter==0): cancel wins, no commit.
- Input changes during WAIT: delay, op and sem are ignored; they are only sampled at start. In intra mode, b and c are also ignored during WAIT.
- Reset asserted mid-WAIT: immediate return to reset values; pending commit is lost.
- Arithmetic: bitwise only, no carry. Result width is exactly WIDTH. The counter never underflows.

Test Plan:
- Intra: reset, b=8'h01, c=8'h00, op=00, sem=0, delay=25, start at cycle 0, b->8'h00 at cycle 10 -> d=8'h01 at cycle 25, done pulse at cycle 25, busy high for cycles 1..25.
- Inter: same stimulus with sem=1 -> d=8'h00 at cycle 25, because b was sampled at the commit edge.
- Ops: b=8'hF0, c=8'h3C, delay=3, op=00/01/10/11 -> d=FC/30/CC/F0, each 3 cycles after its start, issued back-to-back on the done cycle.
- Boundaries:
  - delay=0 -> commit 1 cycle after start;
  - delay=63 (CNT_W=6) -> commit 63 cycles after start;
  - start during WAIT -> err pulse and original commit time unchanged.
- Cancel: start with delay=10, cancel at cycle 4 -> busy drops, no done, d keeps its prior value; cancel+start together at cycle 9 of a new WAIT -> no commit, err=0.
- Reset: rst_n low asynchronously at cycle 5 of a 20-cycle WAIT -> d=RST_VAL and busy=0 immediately; no done after release.
